// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//   Execute stage ALU plus the EX/MEM pipeline register. Operands can be
//   forwarded from this stage's own registered result or from write-back.
//
//   Optional feature macro: EX_FWD_EN
//     defined   -> EX/MEM and WB forwarding onto operand A, operand B
//                  (register form only) and store data
//     undefined -> R1_in / R2_in / wdMem_in are used as-is; the wb* ports
//                  and the rs/rt/srcB inputs are ignored
//
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     aluSig_in[2:0]        ALU op (0 add, 1 sub, 2 and, 3 or, 4 xor,
//                           5 signed slt, 6 B << A[4:0], 7 pass B)
//     WB_in, extendForMem_in, WMEM_in, load_in   control from ID/EX
//     R1_in, R2_in, wdMem_in                     operand A, B, store data
//     rd_in, rs_in, rt_in                        register numbers
//     srcBReg_in            1 = operand B is register rt (forwardable)
//     wbWe_in, wbRd_in, wbData_in                write-back result
//     stall                 hold the register (wins over flush)
//     flush                 capture a bubble: data fields captured,
//                           WB/WMEM/load/ovf forced low
//     aluRes_out, wdMem_out, rd_out, WB_out, extendForMem_out,
//     WMEM_out, load_out, ovf_out                registered outputs
// ---------------------------------------------------------------------------
module ex_mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  aluSig_in,
    input  logic        WB_in,
    input  logic        extendForMem_in,
    input  logic        WMEM_in,
    input  logic        load_in,
    input  logic [31:0] R1_in,
    input  logic [31:0] R2_in,
    input  logic [31:0] wdMem_in,
    input  logic [4:0]  rd_in,
    input  logic [4:0]  rs_in,
    input  logic [4:0]  rt_in,
    input  logic        srcBReg_in,
    input  logic        wbWe_in,
    input  logic [4:0]  wbRd_in,
    input  logic [31:0] wbData_in,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] aluRes_out,
    output logic [31:0] wdMem_out,
    output logic [4:0]  rd_out,
    output logic        WB_out,
    output logic        extendForMem_out,
    output logic        WMEM_out,
    output logic        load_out,
    output logic        ovf_out
);

    logic [31:0] alu_res_q, alu_res_d;
    logic [31:0] wd_mem_q, wd_mem_d;
    logic [4:0]  rd_q, rd_d;
    logic        wb_q, wb_d;
    logic        ext_q, ext_d;
    logic        wmem_q, wmem_d;
    logic        load_q, load_d;
    logic        ovf_q, ovf_d;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] store_data;

`ifdef EX_FWD_EN
    // A load's EX/MEM result is an address, not the loaded value, so it is
    // never a forwarding source; the hazard unit stalls for that case.
    logic exm_hit_rs, exm_hit_rt, wb_hit_rs, wb_hit_rt;

    assign exm_hit_rs = wb_q && !load_q && (rd_q != 5'd0) && (rd_q == rs_in);
    assign exm_hit_rt = wb_q && !load_q && (rd_q != 5'd0) && (rd_q == rt_in);
    assign wb_hit_rs  = wbWe_in && (wbRd_in != 5'd0) && (wbRd_in == rs_in);
    assign wb_hit_rt  = wbWe_in && (wbRd_in != 5'd0) && (wbRd_in == rt_in);

    // EX/MEM is the younger producer, so it takes priority over write-back.
    assign op_a       = exm_hit_rs ? alu_res_q :
                        wb_hit_rs  ? wbData_in : R1_in;
    assign op_b       = (srcBReg_in && exm_hit_rt) ? alu_res_q :
                        (srcBReg_in && wb_hit_rt)  ? wbData_in : R2_in;
    assign store_data = exm_hit_rt ? alu_res_q :
                        wb_hit_rt  ? wbData_in : wdMem_in;
`else
    logic unused_fwd_inputs;

    assign op_a       = R1_in;
    assign op_b       = R2_in;
    assign store_data = wdMem_in;
    assign unused_fwd_inputs = ^{wbWe_in, wbRd_in, wbData_in,
                                 rs_in, rt_in, srcBReg_in};
`endif

    logic [31:0] sum, diff, alu_res;
    logic        alu_ovf;

    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;

    always_comb begin
        alu_res = 32'd0;
        alu_ovf = 1'b0;
        case (aluSig_in)
            3'd0: begin
                alu_res = sum;
                // Same-sign operands producing an opposite-sign sum.
                alu_ovf = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
            end
            3'd1: begin
                alu_res = diff;
                alu_ovf = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
            end
            3'd2: alu_res = op_a & op_b;
            3'd3: alu_res = op_a | op_b;
            3'd4: alu_res = op_a ^ op_b;
            3'd5: alu_res = {31'd0, ($signed(op_a) < $signed(op_b))};
            3'd6: alu_res = op_b << op_a[4:0];
            3'd7: alu_res = op_b;
            default: alu_res = 32'd0;
        endcase
    end

    // Register update: stall holds everything (even under flush); flush
    // still captures the data fields but kills every side-effecting control.
    always_comb begin
        alu_res_d = alu_res_q;
        wd_mem_d  = wd_mem_q;
        rd_d      = rd_q;
        wb_d      = wb_q;
        ext_d     = ext_q;
        wmem_d    = wmem_q;
        load_d    = load_q;
        ovf_d     = ovf_q;
        if (!stall) begin
            alu_res_d = alu_res;
            wd_mem_d  = store_data;
            rd_d      = rd_in;
            ext_d     = extendForMem_in;
            wb_d      = WB_in   && !flush;
            wmem_d    = WMEM_in && !flush;
            load_d    = load_in && !flush;
            ovf_d     = alu_ovf && !flush;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_res_q <= 32'd0;
            wd_mem_q  <= 32'd0;
            rd_q      <= 5'd0;
            wb_q      <= 1'b0;
            ext_q     <= 1'b0;
            wmem_q    <= 1'b0;
            load_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            alu_res_q <= alu_res_d;
            wd_mem_q  <= wd_mem_d;
            rd_q      <= rd_d;
            wb_q      <= wb_d;
            ext_q     <= ext_d;
            wmem_q    <= wmem_d;
            load_q    <= load_d;
            ovf_q     <= ovf_d;
        end
    end

    assign aluRes_out       = alu_res_q;
    assign wdMem_out        = wd_mem_q;
    assign rd_out           = rd_q;
    assign WB_out           = wb_q;
    assign extendForMem_out = ext_q;
    assign WMEM_out         = wmem_q;
    assign load_out         = load_q;
    assign ovf_out          = ovf_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage
//   Self-checking bench for ex_mem_stage. A behavioural model (plain signed
//   arithmetic plus a "latest producer wins" forwarding lookup) predicts the
//   registered outputs each cycle. Forwarding expectations follow EX_FWD_EN.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  aluSig_in;
    logic        WB_in, extendForMem_in, WMEM_in, load_in;
    logic [31:0] R1_in, R2_in, wdMem_in;
    logic [4:0]  rd_in, rs_in, rt_in;
    logic        srcBReg_in;
    logic        wbWe_in;
    logic [4:0]  wbRd_in;
    logic [31:0] wbData_in;
    logic        stall, flush;
    logic [31:0] aluRes_out, wdMem_out;
    logic [4:0]  rd_out;
    logic        WB_out, extendForMem_out, WMEM_out, load_out, ovf_out;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .rst_n(rst_n), .aluSig_in(aluSig_in),
        .WB_in(WB_in), .extendForMem_in(extendForMem_in),
        .WMEM_in(WMEM_in), .load_in(load_in),
        .R1_in(R1_in), .R2_in(R2_in), .wdMem_in(wdMem_in),
        .rd_in(rd_in), .rs_in(rs_in), .rt_in(rt_in),
        .srcBReg_in(srcBReg_in), .wbWe_in(wbWe_in), .wbRd_in(wbRd_in),
        .wbData_in(wbData_in), .stall(stall), .flush(flush),
        .aluRes_out(aluRes_out), .wdMem_out(wdMem_out), .rd_out(rd_out),
        .WB_out(WB_out), .extendForMem_out(extendForMem_out),
        .WMEM_out(WMEM_out), .load_out(load_out), .ovf_out(ovf_out)
    );

`ifdef EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Model of the registered outputs.
    logic [31:0] m_alu, m_wd;
    logic [4:0]  m_rd;
    logic        m_wb, m_ext, m_wmem, m_load, m_ovf;

    logic [73:0] dut_pack, exp_pack;
    assign dut_pack = {aluRes_out, wdMem_out, rd_out, WB_out,
                       extendForMem_out, WMEM_out, load_out, ovf_out};
    assign exp_pack = {m_alu, m_wd, m_rd, m_wb, m_ext, m_wmem, m_load, m_ovf};

    // ---------------- reference model ----------------
    function automatic logic [32:0] alu_ref(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, s;
        logic [31:0] res;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        s   = 0;
        ovf = 1'b0;
        res = 32'd0;
        case (op)
            3'd0: begin s = sa + sb; res = s[31:0];
                        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            3'd1: begin s = sa - sb; res = s[31:0];
                        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: res = (sa < sb) ? 32'd1 : 32'd0;
            3'd6: begin s = longint'(b) * (64'sd1 << a[4:0]); res = s[31:0]; end
            default: res = b;
        endcase
        return {ovf, res};
    endfunction

    // Value seen for register r: the most recent in-flight producer wins.
    function automatic logic [31:0] reg_value(input logic [4:0] r,
                                              input logic [31:0] dflt);
        if (FWD && r != 5'd0) begin
            if (m_wb && !m_load && m_rd == r) return m_alu;
            if (wbWe_in && wbRd_in == r) return wbData_in;
        end
        return dflt;
    endfunction

    task automatic model_reset();
        m_alu = '0; m_wd = '0; m_rd = '0;
        m_wb = 0; m_ext = 0; m_wmem = 0; m_load = 0; m_ovf = 0;
    endtask

    // Advance one clock; model captures from inputs present before the edge.
    task automatic tick();
        logic [31:0] a, b, st;
        logic [32:0] r;
        a  = reg_value(rs_in, R1_in);
        b  = srcBReg_in ? reg_value(rt_in, R2_in) : R2_in;
        st = reg_value(rt_in, wdMem_in);
        r  = alu_ref(aluSig_in, a, b);
        @(posedge clk);
        if (!stall) begin
            m_alu  = r[31:0];
            m_wd   = st;
            m_rd   = rd_in;
            m_ext  = extendForMem_in;
            m_wb   = flush ? 1'b0 : WB_in;
            m_wmem = flush ? 1'b0 : WMEM_in;
            m_load = flush ? 1'b0 : load_in;
            m_ovf  = flush ? 1'b0 : r[32];
        end
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_instr(input logic [2:0] op, input logic [31:0] r1,
                             input logic [31:0] r2, input logic [31:0] wd,
                             input logic [4:0] rd, input logic [4:0] rs,
                             input logic [4:0] rt, input logic srcb,
                             input logic wb, input logic wmem,
                             input logic ld, input logic ext);
        aluSig_in = op; R1_in = r1; R2_in = r2; wdMem_in = wd;
        rd_in = rd; rs_in = rs; rt_in = rt; srcBReg_in = srcb;
        WB_in = wb; WMEM_in = wmem; load_in = ld; extendForMem_in = ext;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] rd,
                          input logic [31:0] data);
        wbWe_in = we; wbRd_in = rd; wbData_in = data;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        stall = 0; flush = 0;
        set_instr(3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1, 0, 0, 0, 0);
        set_wb(0, 5'd0, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (dut_pack !== 74'd0) begin
            tests_failed++;
            $display("FAIL reset_initial: got %h expected 0", dut_pack);
        end
        #3 rst_n = 1'b1;
        set_instr(3'd0, 32'd5, 32'd7, 32'hCAFE, 5'd1, 5'd0, 5'd0, 1'b1, 1, 1, 0, 1);
        tick();
        tests_run++;
        if (aluRes_out !== 32'd12) begin
            tests_failed++;
            $display("FAIL reset_release_add: got %h expected 0000000c", aluRes_out);
        end
        tests_run++;
        if (dut_pack !== exp_pack) begin
            tests_failed++;
            $display("FAIL reset_release_all: got %h expected %h", dut_pack, exp_pack);
        end
        // Mid-cycle async assertion with nonzero outputs.
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        tests_run++;
        if (dut_pack !== 74'd0) begin
            tests_failed++;
            $display("FAIL reset_async_clear: got %h expected 0", dut_pack);
        end
        // Edges while held in reset capture nothing.
        @(posedge clk); #1;
        tests_run++;
        if (dut_pack !== 74'd0) begin
            tests_failed++;
            $display("FAIL reset_held: got %h expected 0", dut_pack);
        end
        #3 rst_n = 1'b1;
        tick();
        // Reset asserted right at a rising edge.
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        tests_run++;
        if (dut_pack !== 74'd0) begin
            tests_failed++;
            $display("FAIL reset_at_edge: got %h expected 0", dut_pack);
        end
        #3 rst_n = 1'b1;
    endtask

    task automatic test_ops();
        logic [2:0]  t_op [13] = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
                                   3'd5, 3'd5, 3'd6, 3'd6, 3'd7, 3'd2};
        logic [31:0] t_a  [13] = '{32'h7FFFFFFF, 32'h80000000, 32'd5, 32'd3,
                                   32'hF0F000FF, 32'hF0000000, 32'hFFFF0000,
                                   32'hFFFFFFFF, 32'h00000000, 32'd4, 32'h24,
                                   32'd123, 32'h7FFFFFFF};
        logic [31:0] t_b  [13] = '{32'd1, 32'd1, 32'd7, 32'd5,
                                   32'h0FF00F0F, 32'h0000000F, 32'h0F0F0F0F,
                                   32'd0, 32'hFFFFFFFF, 32'd3, 32'd1,
                                   32'hDEADBEEF, 32'd1};
        logic [31:0] t_r  [13] = '{32'h80000000, 32'h7FFFFFFF, 32'd12,
                                   32'hFFFFFFFE, 32'h00F0000F, 32'hF000000F,
                                   32'hF0F00F0F, 32'd1, 32'd0, 32'h30, 32'h10,
                                   32'hDEADBEEF, 32'd1};
        logic        t_v  [13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] wd;
        set_wb(0, 5'd0, 32'd0);
        for (int i = 0; i < 13; i++) begin
            wd = $urandom;
            set_instr(t_op[i], t_a[i], t_b[i], wd, 5'd2, 5'd0, 5'd0, 1'b1, 1, 0, 0, 0);
            tick();
            tests_run++;
            if (aluRes_out !== t_r[i] || ovf_out !== t_v[i] || wdMem_out !== wd) begin
                tests_failed++;
                $display("FAIL op_%0d_case_%0d: got res=%h ovf=%b wd=%h expected res=%h ovf=%b wd=%h",
                         t_op[i], i, aluRes_out, ovf_out, wdMem_out, t_r[i], t_v[i], wd);
            end
        end
    endtask

    task automatic test_forwarding();
        logic [31:0] exp;
        set_wb(0, 5'd0, 32'd0);
        set_instr(3'd0, 32'd4, 32'd5, 32'd0, 5'd3, 5'd0, 5'd0, 1'b1, 1, 0, 0, 0);
        tick();
        // EX/MEM (9) beats WB (4) for rs=3.
        set_instr(3'd0, 32'd100, 32'd1, 32'd0, 5'd4, 5'd3, 5'd0, 1'b1, 1, 0, 0, 0);
        set_wb(1, 5'd3, 32'd4);
        tick();
        exp = FWD ? 32'd10 : 32'd101;
        tests_run++;
        if (aluRes_out !== exp) begin
            tests_failed++;
            $display("FAIL fwd_exmem_priority: got %h expected %h", aluRes_out, exp);
        end
        // Only WB matches rs=3.
        set_instr(3'd0, 32'd100, 32'd1, 32'd0, 5'd0, 5'd3, 5'd0, 1'b1, 1, 0, 0, 0);
        tick();
        exp = FWD ? 32'd5 : 32'd101;
        tests_run++;
        if (aluRes_out !== exp) begin
            tests_failed++;
            $display("FAIL fwd_wb_only: got %h expected %h", aluRes_out, exp);
        end
        // EX/MEM rd=0 and WB rd=0 must never forward onto rs=0.
        set_instr(3'd0, 32'd20, 32'd2, 32'd0, 5'd6, 5'd0, 5'd0, 1'b1, 1, 0, 0, 0);
        set_wb(1, 5'd0, 32'h55);
        tick();
        tests_run++;
        if (aluRes_out !== 32'd22) begin
            tests_failed++;
            $display("FAIL fwd_reg0: got %h expected 00000016", aluRes_out);
        end
        // Immediate B is untouched; store data on rt=6 is forwarded.
        set_instr(3'd7, 32'd0, 32'h77, 32'hAB, 5'd1, 5'd0, 5'd6, 1'b0, 1, 1, 0, 0);
        set_wb(0, 5'd0, 32'd0);
        tick();
        exp = FWD ? 32'd22 : 32'hAB;
        tests_run++;
        if (aluRes_out !== 32'h77 || wdMem_out !== exp) begin
            tests_failed++;
            $display("FAIL fwd_store_imm: got res=%h wd=%h expected res=00000077 wd=%h",
                     aluRes_out, wdMem_out, exp);
        end
    endtask

    task automatic test_load();
        logic [31:0] exp;
        set_wb(0, 5'd0, 32'd0);
        set_instr(3'd0, 32'h20, 32'd0, 32'd0, 5'd5, 5'd0, 5'd0, 1'b1, 1, 0, 1, 1);
        tick();
        set_instr(3'd0, 32'h99, 32'd0, 32'd0, 5'd7, 5'd5, 5'd0, 1'b1, 1, 0, 0, 0);
        set_wb(1, 5'd5, 32'h11);
        tick();
        exp = FWD ? 32'h11 : 32'h99;
        tests_run++;
        if (aluRes_out !== exp) begin
            tests_failed++;
            $display("FAIL load_wb_match: got %h expected %h", aluRes_out, exp);
        end
        set_wb(0, 5'd0, 32'd0);
        set_instr(3'd0, 32'h20, 32'd0, 32'd0, 5'd5, 5'd0, 5'd0, 1'b1, 1, 0, 1, 1);
        tick();
        set_instr(3'd0, 32'h99, 32'd0, 32'd0, 5'd7, 5'd5, 5'd0, 1'b1, 1, 0, 0, 0);
        tick();
        tests_run++;
        if (aluRes_out !== 32'h99) begin
            tests_failed++;
            $display("FAIL load_no_fwd: got %h expected 00000099", aluRes_out);
        end
    endtask

    task automatic test_stall_flush();
        set_wb(0, 5'd0, 32'd0);
        set_instr(3'd0, 32'd1, 32'd2, 32'h5A, 5'd8, 5'd0, 5'd0, 1'b1, 1, 1, 0, 1);
        tick();
        stall = 1; flush = 1;
        set_instr(3'd1, 32'd50, 32'd9, 32'h66, 5'd9, 5'd0, 5'd0, 1'b1, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            tests_run++;
            if (aluRes_out !== 32'd3 || rd_out !== 5'd8 || WB_out !== 1'b1 ||
                WMEM_out !== 1'b1 || wdMem_out !== 32'h5A || dut_pack !== exp_pack) begin
                tests_failed++;
                $display("FAIL stall_flush_hold_%0d: got %h expected %h", i, dut_pack, exp_pack);
            end
        end
        stall = 0; flush = 1;
        set_instr(3'd0, 32'h7FFFFFFF, 32'd1, 32'h33, 5'd9, 5'd0, 5'd0, 1'b1, 1, 1, 1, 1);
        tick();
        tests_run++;
        if (WMEM_out !== 1'b0 || WB_out !== 1'b0 || load_out !== 1'b0 ||
            ovf_out !== 1'b0 || rd_out !== 5'd9 || aluRes_out !== 32'h80000000 ||
            extendForMem_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_bubble: got wmem=%b wb=%b ld=%b ovf=%b rd=%0d res=%h ext=%b expected 0 0 0 0 9 80000000 1",
                     WMEM_out, WB_out, load_out, ovf_out, rd_out, aluRes_out, extendForMem_out);
        end
        flush = 0;
    endtask

    task automatic test_random();
        logic [31:0] edge_vals [4] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd0};
        for (int i = 0; i < 400; i++) begin
            aluSig_in       = 3'($urandom_range(0, 7));
            R1_in           = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            R2_in           = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            wdMem_in        = $urandom;
            rd_in           = 5'($urandom_range(0, 7));
            rs_in           = 5'($urandom_range(0, 7));
            rt_in           = 5'($urandom_range(0, 7));
            srcBReg_in      = 1'($urandom_range(0, 1));
            WB_in           = 1'($urandom_range(0, 1));
            WMEM_in         = 1'($urandom_range(0, 1));
            load_in         = 1'($urandom_range(0, 1));
            extendForMem_in = 1'($urandom_range(0, 1));
            wbWe_in         = 1'($urandom_range(0, 1));
            wbRd_in         = 5'($urandom_range(0, 7));
            wbData_in       = $urandom;
            stall           = ($urandom_range(0, 7) == 0);
            flush           = ($urandom_range(0, 7) == 0);
            tick();
            tests_run++;
            if (dut_pack !== exp_pack) begin
                tests_failed++;
                $display("FAIL random_%0d: got %h expected %h", i, dut_pack, exp_pack);
            end
        end
        stall = 0; flush = 0;
    endtask

    initial begin
        test_reset();
        test_ops();
        test_forwarding();
        test_load();
        test_stall_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
